// File: rtl/clock_enable_controller_if.sv
// Control/status bundle for clock_enable_controller.
//   master: debug/bring-up side; drives requests and configuration, observes status.
//   slave : the controller itself.
// Signals:
//   cfg_div/cfg_load           divide-ratio programming (accepted only while halted)
//   run_req/halt_req/step_req  one-cycle mode requests; step_count is sampled with step_req
//   ce/clk_div                 clock-enable pulse and divided clock
//   busy/state                 activity flag and mode (HALT=00, RUN=01, STEP=10)
//   step_done/cfg_err          one-cycle completion and rejected-config pulses
// Optional (CLOCK_ENABLE_CYCLE_COUNTER_EN): ce_count_clr input, 32-bit ce_count output.
interface clock_enable_controller_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_load;
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic [CNT_W-1:0] step_count;
  logic             ce;
  logic             clk_div;
  logic             busy;
  logic [1:0]       state;
  logic             step_done;
  logic             cfg_err;
`ifdef CLOCK_ENABLE_CYCLE_COUNTER_EN
  logic             ce_count_clr;
  logic [31:0]      ce_count;
`endif

  modport master (
    output cfg_div, cfg_load, run_req, halt_req, step_req, step_count,
    input  ce, clk_div, busy, state, step_done, cfg_err
`ifdef CLOCK_ENABLE_CYCLE_COUNTER_EN
    , output ce_count_clr
    , input  ce_count
`endif
  );

  modport slave (
    input  cfg_div, cfg_load, run_req, halt_req, step_req, step_count,
    output ce, clk_div, busy, state, step_done, cfg_err
`ifdef CLOCK_ENABLE_CYCLE_COUNTER_EN
    , input  ce_count_clr
    , output ce_count
`endif
  );
endinterface

// File: rtl/clock_enable_controller.sv
// Run/halt/single-step controller producing the core clock-enable from clk50.
// Ports:
//   clk50  sole clock, rising edge
//   reset  synchronous, active-high
//   ctl    clock_enable_controller_if.slave (requests, config and status, see interface)
// Optional macro CLOCK_ENABLE_CYCLE_COUNTER_EN adds a 32-bit ce_count with ce_count_clr.
// All outputs come straight from registers.
module clock_enable_controller #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input logic                        clk50,
  input logic                        reset,
  clock_enable_controller_if.slave   ctl
);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivReset = DIV_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ce_q, ce_d;
  logic             clk_div_q, clk_div_d;
  logic             busy_q, busy_d;
  logic             step_done_q, step_done_d;
  logic             cfg_err_q, cfg_err_d;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = '0;  // zero while halted, so every RUN/STEP entry starts from a cleared count
    rem_d       = rem_q;
    ce_d        = 1'b0;
    step_done_d = 1'b0;

    case (state_q)
      StHalt: begin
        if (ctl.cfg_load) begin
          div_d = (ctl.cfg_div == '0) ? DivOne : ctl.cfg_div;
        end
        // halt_req has top priority but does nothing while already halted
        if (!ctl.halt_req) begin
          if (ctl.step_req) begin
            if (ctl.step_count != '0) begin
              state_d = StStep;
              rem_d   = ctl.step_count;
            end else begin
              step_done_d = 1'b1;
            end
          end else if (ctl.run_req) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (ctl.halt_req) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        // ce_q is the pulse currently on the output; count it now
        if (ce_q && rem_q != '0) begin
          rem_d = rem_q - RemOne;
        end
        if (ctl.halt_req) begin
          state_d = StHalt;
          rem_d   = '0;
        end else if (ce_q && rem_q == RemOne) begin
          state_d     = StHalt;
          step_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StHalt;
        rem_d   = '0;
      end
    endcase

    cfg_err_d = ctl.cfg_load && (state_q != StHalt);

    // Divider runs only while staying active; leaving suppresses any further ce.
    if (state_q != StHalt && state_d != StHalt) begin
      ce_d  = (cnt_q == div_q - DivOne);
      cnt_d = ce_d ? '0 : cnt_q + DivOne;
    end

    busy_d    = (state_d != StHalt);
    clk_div_d = clk_div_q ^ ce_d;
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q     <= StHalt;
      div_q       <= DivReset;
      cnt_q       <= '0;
      rem_q       <= '0;
      ce_q        <= 1'b0;
      clk_div_q   <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      ce_q        <= ce_d;
      clk_div_q   <= clk_div_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ctl.ce        = ce_q;
  assign ctl.clk_div   = clk_div_q;
  assign ctl.busy      = busy_q;
  assign ctl.state     = state_q;
  assign ctl.step_done = step_done_q;
  assign ctl.cfg_err   = cfg_err_q;

`ifdef CLOCK_ENABLE_CYCLE_COUNTER_EN
  logic [31:0] ce_count_q;

  // Counts pulses as they appear on ce; clear beats a coincident increment.
  always_ff @(posedge clk50) begin
    if (reset || ctl.ce_count_clr) begin
      ce_count_q <= '0;
    end else if (ce_q) begin
      ce_count_q <= ce_count_q + 32'd1;
    end
  end

  assign ctl.ce_count = ce_count_q;
`endif

endmodule

// File: doc/clock_enable_controller.md
Name: clock_enable_controller

Overview:
- Run/halt/single-step controller for the processor core clock.
- Derives a one-cycle clock-enable pulse (ce) and a divided clock (clk_div) from clk50 using a runtime-programmable divide ratio.
- Lets the debug/bring-up logic start, stop, or step the pipeline N core cycles at a time.
- Sits between the board clock input and the pipeline's clock-enable inputs.

Parameters:
- DIV_W, 8, width of the divide-ratio register.
- CNT_W, 16, width of the step-count input and the remaining-steps counter.
- DEFAULT_DIV, 5, divide ratio loaded at reset. Must be >= 1.

Ports:
- clk50  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_div  input  DIV_W  new divide ratio.
- cfg_load  input  1  pulse; latch cfg_div into div_reg.
- run_req  input  1  pulse; enter free-running mode.
- halt_req  input  1  pulse; stop issuing ce.
- step_req  input  1  pulse; issue step_count ce pulses, then halt.
- step_count  input  CNT_W  number of ce pulses for a step; sampled with step_req.
- ce  output  1  clock-enable pulse, one clk50 cycle wide.
- clk_div  output  1  divided clock; toggles on every ce.
- busy  output  1  high when state != HALT.
- state  output  2  HALT=00, RUN=01, STEP=10.
- step_done  output  1  one-cycle pulse when a step sequence completes.
- cfg_err  output  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (sampled on a clk50 edge):
  - state=HALT, div_reg=DEFAULT_DIV, cnt=0, remaining=0.
  - ce=0, clk_div=0, busy=0, step_done=0, cfg_err=0.
  - Reset mid-RUN or mid-STEP aborts immediately; no step_done is generated.
- All outputs are registered.
- Divide ratio:
  - cfg_load is accepted only in HALT. cfg_div=0 is stored as 1.
  - cfg_load in RUN or STEP is ignored, and cfg_err pulses on the next cycle.
  - The new ratio applies from the next RUN/STEP entry.
- Divider counter cnt (DIV_W bits):
  - Cleared on every transition into RUN or STEP.
  - In RUN/STEP, increments each cycle and wraps to 0 after reaching div_reg-1.
  - ce is registered high for the cycle after cnt==div_reg-1.
  - So the first ce appears div_reg cycles after the state register changes, then every div_reg cycles.
  - div_reg=1: ce stays high continuously while active.
- clk_div toggles in the same cycle ce is high; period = 2*div_reg clk50 cycles. It holds its level in HALT.
- HALT:
  - Request priority: halt_req > step_req > run_req.
  - run_req -> RUN.
  - step_req with step_count>0 -> STEP, remaining=step_count.
  - step_req with step_count=0 -> stay in HALT; step_done pulses next cycle.
  - halt_req is a no-op.
- RUN:
  - halt_req -> HALT on the next edge. A ce already registered for that cycle still appears; no further ce after it.
  - step_req and run_req are ignored.
- STEP:
  - Each ce issued decrements remaining.
  - When the ce carrying remaining==1 is issued, the state returns to HALT.
  - step_done pulses in the cycle after that final ce.
  - halt_req aborts to HALT with no step_done; remaining is cleared.
  - run_req and step_req are ignored.
- Simultaneous halt_req with the final step ce: the ce is still issued; halt wins, so no step_done.
- remaining uses CNT_W bits and never wraps below 0.
- Exactly step_count ce pulses are issued per completed step.

Optional Feature:
- Macro: CLOCK_ENABLE_CYCLE_COUNTER_EN.
- Defined:
  - Adds output ce_count (32 bits), reset to 0, incremented on every ce.
  - Wraps 0xFFFFFFFF -> 0.
  - Adds input ce_count_clr (1 bit); clears the counter on the next edge. Clear has priority over a coincident increment.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Test Plan:
- Reset, then run_req with DEFAULT_DIV=5 -> busy=1 and state=01 one cycle later; first ce 5 cycles after state=01; ce period 5; clk_div period 10.
- In HALT: cfg_load with cfg_div=0, then run_req -> ce high every cycle. cfg_load with cfg_div=3 while in RUN -> cfg_err pulse; ce period unchanged.
- div=4, step_req with step_count=3 -> exactly 3 ce pulses, 4 cycles apart; state=00 and step_done=1 in the cycle after the 3rd ce; busy=0.
- step_req with step_count=0 -> state stays 00; step_done pulses once; no ce.
- div=2, step_count=10, halt_req after the 4th ce -> state=00 with no further ce and no step_done. Repeat with reset asserted after the 2nd ce -> all outputs at reset values on the next cycle.
- With CLOCK_ENABLE_CYCLE_COUNTER_EN: run 7 ce pulses -> ce_count=7. Assert ce_count_clr coincident with a ce -> ce_count=0.
